u_recv: RTL

- UART receive path; counterpart of the team's 16x-oversampled UART transmitter.
- Synchronises the serial line and detects a start bit.
- Samples each bit at cell centre and assembles an LSB-first word.
- Presents the word to the host with a valid/ack handshake, and flags framing and overrun errors.

---
 rtl/u_recv_pkg.sv | 37 +++
 rtl/u_recv_sync.sv | 54 +++++
 rtl/u_recv.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/u_recv_pkg.sv
// Shared definitions for the u_recv UART receive path: receive state
// encodings, line-level constants, the default word length, the bit-cell
// decision counts and the 2-of-3 vote helper used when
// U_RECV_MAJORITY_VOTE_EN is defined.
package u_recv_pkg;

    // Default number of data bits per frame (no parity, one stop bit).
    localparam int WORD_LEN_DEF = 8;

    // Serial line levels; the line idles high.
    localparam logic LO = 1'b0;
    localparam logic HI = 1'b1;

    // Cell count at which the start bit is judged (middle of the start cell,
    // measured from the first cycle the synchronised line was seen low).
    localparam int START_CENTRE = 7;

    // Cell count at which data and stop bits are judged. The start decision
    // already sits mid-cell, so the last count of each following cell lands
    // at the centre of that bit.
    localparam int DATA_CENTRE = 15;

    // Receive state encodings.
    typedef enum logic [2:0] {
        r_IDLE  = 3'd0,
        r_START = 3'd1,
        r_DATA  = 3'd2,
        r_STOP  = 3'd3,
        r_BREAK = 3'd4
    } recvState_t;

    // Two-of-three majority of three line samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/u_recv_sync.sv
// Input conditioning for u_recv: two-flop synchroniser for the asynchronous
// serial line, resetting to the idle (high) level. When
// U_RECV_MAJORITY_VOTE_EN is defined, it also keeps the two previous
// synchronised samples and presents their 2-of-3 vote with the current one
// as the bit value; otherwise the bit value is the synchronised line itself.
module u_recv_sync
    import u_recv_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst_l,
    input  logic uart_recvH,
    output logic rxS,
    output logic bitS
);

    logic syncMetaR;
    logic syncR;

    // Two-stage synchroniser; both stages reset to the idle line level.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            syncMetaR <= HI;
            syncR     <= HI;
        end else begin
            syncMetaR <= uart_recvH;
            syncR     <= syncMetaR;
        end
    end

    assign rxS = syncR;

`ifdef U_RECV_MAJORITY_VOTE_EN
    logic histD1R;
    logic histD2R;

    // History of the two previous synchronised samples for the 3-sample vote.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            histD1R <= HI;
            histD2R <= HI;
        end else begin
            histD1R <= syncR;
            histD2R <= histD1R;
        end
    end

    // The vote covers the current cycle and the two before it, so the
    // decision is taken one count later than the single-sample centre.
    assign bitS = majority3(syncR, histD1R, histD2R);
`else
    assign bitS = syncR;
`endif

endmodule

// File: rtl/u_recv.sv
// u_recv: UART receiver, counterpart of the 16x-oversampled transmitter.
// Synchronises the line, detects and qualifies the start bit, samples each
// bit at cell centre, assembles an LSB-first word and hands it to the host
// over a valid/ack handshake. Framing errors and overruns are flagged with
// one-cycle pulses.
// Optional feature: define U_RECV_MAJORITY_VOTE_EN to judge every bit by a
// 2-of-3 vote around the cell centre (one extra cycle of decision latency).
module u_recv
    import u_recv_pkg::*;
#(
    parameter int WORD_LEN   = WORD_LEN_DEF,
    parameter int CELL_CNT_W = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst_l,
    input  logic                uart_recvH,
    output logic [WORD_LEN-1:0] rec_dataH,
    output logic                rec_validH,
    input  logic                rec_ackH,
    output logic                rec_busyH,
    output logic                frame_errH,
    output logic                overrunH
);

    localparam int BIT_CNT_W = $clog2(WORD_LEN + 1);

`ifdef U_RECV_MAJORITY_VOTE_EN
    // The vote needs the sample after the centre, so every decision moves
    // one count later; the start shift carries through to data and stop.
    localparam int START_DEC_CNT = START_CENTRE + 1;
`else
    localparam int START_DEC_CNT = START_CENTRE;
`endif

    localparam logic [CELL_CNT_W-1:0] START_DEC = CELL_CNT_W'(START_DEC_CNT);
    localparam logic [CELL_CNT_W-1:0] DATA_DEC  = CELL_CNT_W'(DATA_CENTRE);
    localparam logic [CELL_CNT_W-1:0] CELL_ONE  = CELL_CNT_W'(32'd1);
    localparam logic [BIT_CNT_W-1:0]  BIT_ONE   = BIT_CNT_W'(32'd1);
    localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(WORD_LEN - 1);

    logic rxS;
    logic bitS;

    recvState_t            stateR;
    logic [CELL_CNT_W-1:0] cellCntR;
    logic [BIT_CNT_W-1:0]  bitCntR;
    logic [WORD_LEN-1:0]   shregR;
    logic [WORD_LEN-1:0]   recDataR;
    logic                  recValidR;
    logic                  busyR;
    logic                  frameErrR;
    logic                  overrunR;

    u_recv_sync u_sync (
        .sys_clk    (sys_clk),
        .sys_rst_l  (sys_rst_l),
        .uart_recvH (uart_recvH),
        .rxS        (rxS),
        .bitS       (bitS)
    );

    // Receive FSM with counters, shift register and all registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            stateR    <= r_IDLE;
            cellCntR  <= '0;
            bitCntR   <= '0;
            shregR    <= '0;
            recDataR  <= '0;
            recValidR <= LO;
            busyR     <= LO;
            frameErrR <= LO;
            overrunR  <= LO;
        end else begin
            // Pulses last a single cycle unless re-asserted below.
            frameErrR <= LO;
            overrunR  <= LO;

            // Host ack consumes the held word; a good frame completing in
            // the same cycle overrides this in r_STOP.
            if (rec_ackH && recValidR) begin
                recValidR <= LO;
            end else begin
                recValidR <= recValidR;
            end

            case (stateR)
                r_IDLE: begin
                    cellCntR <= '0;
                    bitCntR  <= '0;
                    if (rxS == LO) begin
                        stateR <= r_START;
                        busyR  <= HI;
                    end else begin
                        stateR <= r_IDLE;
                        busyR  <= LO;
                    end
                end

                r_START: begin
                    if (cellCntR == START_DEC) begin
                        cellCntR <= '0;
                        if (bitS == LO) begin
                            stateR <= r_DATA;
                            busyR  <= HI;
                        end else begin
                            // Glitch shorter than half a bit: not a start.
                            stateR <= r_IDLE;
                            busyR  <= LO;
                        end
                    end else begin
                        cellCntR <= cellCntR + CELL_ONE;
                        stateR   <= r_START;
                        busyR    <= HI;
                    end
                end

                r_DATA: begin
                    // Cell counter wraps naturally at the end of each cell.
                    cellCntR <= cellCntR + CELL_ONE;
                    busyR    <= HI;
                    if (cellCntR == DATA_DEC) begin
                        // LSB arrives first, so new bits enter at the top.
                        shregR  <= (shregR >> 32'd1) | (WORD_LEN'(bitS) << (WORD_LEN - 1));
                        bitCntR <= bitCntR + BIT_ONE;
                        if (bitCntR == BIT_LAST) begin
                            stateR <= r_STOP;
                        end else begin
                            stateR <= r_DATA;
                        end
                    end else begin
                        stateR <= r_DATA;
                    end
                end

                r_STOP: begin
                    cellCntR <= cellCntR + CELL_ONE;
                    if (cellCntR == DATA_DEC) begin
                        if (bitS == HI) begin
                            // Good frame: publish, overwriting an unread word.
                            recDataR  <= shregR;
                            recValidR <= HI;
                            if (recValidR && !rec_ackH) begin
                                overrunR <= HI;
                            end else begin
                                overrunR <= LO;
                            end
                            stateR <= r_IDLE;
                            busyR  <= LO;
                        end else begin
                            // Stop bit low: keep the last good word, wait
                            // for the line to recover before re-arming.
                            frameErrR <= HI;
                            stateR    <= r_BREAK;
                            busyR     <= HI;
                        end
                    end else begin
                        stateR <= r_STOP;
                        busyR  <= HI;
                    end
                end

                r_BREAK: begin
                    cellCntR <= '0;
                    bitCntR  <= '0;
                    if (rxS == HI) begin
                        stateR <= r_IDLE;
                        busyR  <= LO;
                    end else begin
                        stateR <= r_BREAK;
                        busyR  <= HI;
                    end
                end

                default: begin
                    // Unused encodings fall back to idle.
                    stateR   <= r_IDLE;
                    cellCntR <= '0;
                    bitCntR  <= '0;
                    busyR    <= LO;
                end
            endcase
        end
    end

    assign rec_dataH  = recDataR;
    assign rec_validH = recValidR;
    assign rec_busyH  = busyR;
    assign frame_errH = frameErrR;
    assign overrunH   = overrunR;

endmodule
